// File: rtl/shift_req_stage.sv
// Operand-feed / result-capture stage around the combinational SHIFT32 barrel shifter.
// Requests queue in a small FIFO; the head drives the shifter, and results return over valid/ready.
module shift_req_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [31:0]      REQ_DATA,
  input  logic [31:0]      REQ_AMT,
  input  logic             REQ_LNR,
  output logic [31:0]      SH_D,
  output logic [31:0]      SH_S,
  output logic             SH_LNR,
  input  logic [31:0]      SH_Y,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [31:0]      RSP_DATA,
  output logic             RSP_ZERO,
  output logic [CNT_W-1:0] OP_COUNT
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] amt;
    logic        lnr;
  } req_t;

  req_t          mem [DEPTH];
  req_t          head;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          full, push, issue;

  assign full      = (count == (AW+1)'(DEPTH));
  assign REQ_READY = !full;
  assign push      = REQ_VALID && !full;
  assign issue     = (count != '0) && (!RSP_VALID || RSP_READY);

  // Popped slots are cleared, so an empty queue presents zeros to the shifter
  // without any gating between the storage registers and SH_*.
  assign head   = mem[rd_ptr];
  assign SH_D   = head.data;
  assign SH_S   = head.amt;
  assign SH_LNR = head.lnr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // push and issue together imply 0 < count < DEPTH, so wr_ptr != rd_ptr
      if (push) begin
        mem[wr_ptr] <= {REQ_DATA, REQ_AMT, REQ_LNR};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (issue) begin
        mem[rd_ptr] <= '0;
        rd_ptr      <= rd_ptr + AW'(1);
      end
      case ({push, issue})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_ZERO  <= 1'b0;
      OP_COUNT  <= '0;
    end else begin
      if (issue) begin
        RSP_DATA  <= SH_Y;
        RSP_ZERO  <= (SH_Y == '0);
        RSP_VALID <= 1'b1;
      end else if (RSP_READY) begin
        RSP_VALID <= 1'b0;
      end
      if (RSP_VALID && RSP_READY) OP_COUNT <= OP_COUNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_shift_req_stage.sv
// Bench for shift_req_stage: behavioural shifter, transaction-level queue model
// checked every cycle, plus directed latency/backpressure/wrap/reset steps.
module tb_shift_req_stage;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             REQ_VALID, REQ_READY, REQ_LNR;
  logic [31:0]      REQ_DATA, REQ_AMT;
  logic [31:0]      SH_D, SH_S, SH_Y;
  logic             SH_LNR;
  logic             RSP_VALID, RSP_READY, RSP_ZERO;
  logic [31:0]      RSP_DATA;
  logic [CNT_W-1:0] OP_COUNT;

  int total = 0;
  int bad   = 0;

  shift_req_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_DATA(REQ_DATA),
    .REQ_AMT(REQ_AMT), .REQ_LNR(REQ_LNR),
    .SH_D(SH_D), .SH_S(SH_S), .SH_LNR(SH_LNR), .SH_Y(SH_Y),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
    .RSP_ZERO(RSP_ZERO), .OP_COUNT(OP_COUNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] shf(input logic [31:0] d, input logic [31:0] a, input logic l);
    if (a >= 32) return 32'd0;
    return l ? (d << a[4:0]) : (d >> a[4:0]);
  endfunction

  assign SH_Y = shf(SH_D, SH_S, SH_LNR);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: requests waiting, one held response, handshake count.
  typedef struct { logic [31:0] d; logic [31:0] a; logic l; } rq_t;
  rq_t         q[$];
  bit          m_rv;
  logic [31:0] m_data;
  int          m_cnt;

  task automatic monitor();
    bit hs, iss, psh;
    rq_t r;
    forever begin
      @(negedge CLK);
      if (RST) begin
        q.delete();
        m_rv  = 0;
        m_cnt = 0;
      end else begin
        chk("m_rdy", REQ_READY, q.size() != DEPTH);
        chk("m_rv", RSP_VALID, m_rv);
        if (m_rv) begin
          chk("m_data", RSP_DATA, m_data);
          chk("m_zero", RSP_ZERO, m_data == 0);
        end
        chk("m_cnt", OP_COUNT, 32'(m_cnt % 16));
        chk("m_shd", SH_D, q.size() ? q[0].d : 32'd0);
        chk("m_shs", SH_S, q.size() ? q[0].a : 32'd0);
        chk("m_shl", SH_LNR, q.size() ? q[0].l : 1'b0);
        hs  = m_rv && RSP_READY;
        iss = (q.size() > 0) && (!m_rv || RSP_READY);
        psh = REQ_VALID && (q.size() != DEPTH);
        if (hs) m_cnt++;
        if (iss) begin
          r = q.pop_front();
          m_data = shf(r.d, r.a, r.l);
          m_rv = 1;
        end else if (hs) m_rv = 0;
        if (psh) begin
          r.d = REQ_DATA; r.a = REQ_AMT; r.l = REQ_LNR;
          q.push_back(r);
        end
      end
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] a, input logic l);
    bit ok;
    int k = 0;
    REQ_VALID = 1; REQ_DATA = d; REQ_AMT = a; REQ_LNR = l;
    do begin
      @(negedge CLK); ok = REQ_READY;
      @(posedge CLK); #1; k++;
    end while (!ok && k < 20);
    chk("send_accept", ok, 1);
  endtask

  task automatic stream(input int n);
    int v = 0;
    RSP_READY = 1;
    for (int i = 0; i < n; i++) begin
      REQ_VALID = 1; REQ_DATA = $urandom; REQ_AMT = $urandom_range(0, 35); REQ_LNR = 1'($urandom_range(0, 1));
      @(negedge CLK); chk("strm_rdy", REQ_READY, 1);
      @(posedge CLK); #1;
      if (RSP_VALID) v++;
    end
    REQ_VALID = 0;
    @(posedge CLK); #1;
    if (RSP_VALID) v++;
    chk("strm_results", v, n);
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  initial begin
    RST = 1; REQ_VALID = 0; REQ_DATA = 0; REQ_AMT = 0; REQ_LNR = 0; RSP_READY = 1;
    fork monitor(); join_none
    #1;
    chk("rst_rv", RSP_VALID, 0);
    chk("rst_data", RSP_DATA, 0);
    chk("rst_cnt", OP_COUNT, 0);
    chk("rst_shd", SH_D, 0);
    step(); step();
    RST = 0;
    step();
    chk("rst_rdy", REQ_READY, 1);

    // 1 << 1, two-edge latency
    send(32'd1, 32'd1, 1'b1);
    REQ_VALID = 0;
    step();
    chk("t1_rv", RSP_VALID, 1);
    chk("t1_data", RSP_DATA, 2);
    chk("t1_zero", RSP_ZERO, 0);
    step();
    chk("t1_cnt", OP_COUNT, 1);

    // back-to-back, amounts >= 32
    send(32'd10, 32'd3, 1'b0);
    send(32'd1, 32'd32, 1'b1);
    chk("t2_a", RSP_DATA, 1);
    send(32'd100, 32'd33, 1'b1);
    REQ_VALID = 0;
    chk("t2_b", RSP_DATA, 0);
    chk("t2_bz", RSP_ZERO, 1);
    step();
    chk("t2_c", RSP_DATA, 0);
    chk("t2_cv", RSP_VALID, 1);
    step(); step();

    // backpressure
    RSP_READY = 0;
    send(32'd15, 32'd5, 1'b1);
    send(32'd100, 32'd5, 1'b0);
    send(32'd100, 32'd10, 1'b1);
    REQ_VALID = 1; REQ_DATA = 32'd7; REQ_AMT = 32'd1; REQ_LNR = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t3_full", REQ_READY, 0);
      chk("t3_hold", RSP_DATA, 480);
      step();
    end
    REQ_VALID = 0;
    RSP_READY = 1;
    step(); chk("t3_r2", RSP_DATA, 3);
    step(); chk("t3_r3", RSP_DATA, 102400);
    step(); chk("t3_idle", RSP_VALID, 0);
    chk("t3_cnt", OP_COUNT, 7);

    // streaming
    stream(8);
    step();
    chk("t4_cnt", OP_COUNT, 15);

    // random traffic against the model
    for (int i = 0; i < 200; i++) begin
      REQ_VALID = 1'($urandom_range(0, 1));
      REQ_DATA  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      REQ_AMT   = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40));
      REQ_LNR   = 1'($urandom_range(0, 1));
      RSP_READY = ($urandom_range(0, 3) != 0);
      step();
    end
    REQ_VALID = 0; RSP_READY = 1;
    repeat (5) step();

    // async reset with a held response and a full queue
    RSP_READY = 0;
    send(32'd3, 32'd1, 1'b1);
    send(32'd4, 32'd1, 1'b1);
    send(32'd5, 32'd1, 1'b1);
    REQ_VALID = 0;
    chk("t6_pre", RSP_VALID, 1);
    #1 RST = 1;
    #1;
    chk("t6_rv", RSP_VALID, 0);
    chk("t6_data", RSP_DATA, 0);
    chk("t6_zero", RSP_ZERO, 0);
    chk("t6_cnt", OP_COUNT, 0);
    chk("t6_shd", SH_D, 0);
    chk("t6_shs", SH_S, 0);
    step();
    RST = 0; RSP_READY = 1;
    chk("t6_rdy", REQ_READY, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_stale", RSP_VALID, 0);
    end

    // counter wrap
    stream(17);
    step();
    chk("t5_wrap", OP_COUNT, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
